decode_stage_controller: RTL

- Owns the IF/ID and ID/EX pipeline registers around the decode stage.
- Decodes the opcode of the instruction held in ID into the 3-bit immediate-select code consumed by the immediate generation unit.
- Detects load-use hazards and inserts bubbles.
- Applies stall and branch flush, and counts hazard bubbles for performance monitoring.

---
 rtl/decode_stage_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/decode_stage_controller.sv
// decode_stage_controller: IF/ID and ID/EX pipeline registers with immediate-select decode,
// load-use bubble insertion, stall/flush handling and a saturating bubble counter.
module decode_stage_controller #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            IF_INSTRUCTION,
  input  logic [31:0]            IF_PC,
  input  logic                   IF_VALID,
  input  logic                   EX_STALL,
  input  logic                   BRANCH_TAKEN,
  output logic [31:0]            ID_INSTRUCTION,
  output logic [31:0]            ID_PC,
  output logic                   ID_VALID,
  output logic [2:0]             IMM_SELECT,
  output logic [31:0]            EX_INSTRUCTION,
  output logic [31:0]            EX_PC,
  output logic [2:0]             EX_IMM_SELECT,
  output logic                   EX_VALID,
  output logic                   IF_STALL,
  output logic [COUNT_WIDTH-1:0] HAZARD_COUNT
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  logic [31:0]            id_instr_q, id_instr_d, id_pc_q, id_pc_d;
  logic [31:0]            ex_instr_q, ex_instr_d, ex_pc_q, ex_pc_d;
  logic                   id_valid_q, id_valid_d, ex_valid_q, ex_valid_d;
  logic [2:0]             ex_imm_q, ex_imm_d, imm_sel;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [6:0]             id_op;
  logic [4:0]             ex_rd;
  logic                   use_rs1, use_rs2, load_use;
  always_comb begin
    id_op    = id_instr_q[6:0];
    ex_rd    = ex_instr_q[11:7];
    imm_sel  = (id_op == OP_LUI || id_op == OP_AUIPC) ? 3'b000 :
               (id_op == OP_JAL) ? 3'b001 :
               (id_op == OP_JALR || id_op == OP_LOAD || id_op == OP_OPIMM) ? 3'b010 :
               (id_op == OP_BRANCH) ? 3'b011 :
               (id_op == OP_STORE) ? 3'b100 : 3'b111;
    use_rs1  = id_op inside {OP_JALR, OP_LOAD, OP_OPIMM, OP_BRANCH, OP_STORE, OP_OP};
    use_rs2  = id_op inside {OP_BRANCH, OP_STORE, OP_OP};
    load_use = id_valid_q && ex_valid_q && ex_instr_q[6:0] == OP_LOAD && ex_rd != 5'd0 &&
               ((use_rs1 && id_instr_q[19:15] == ex_rd) || (use_rs2 && id_instr_q[24:20] == ex_rd));
  end
  // Priority: flush, then stall hold, then load-use bubble, then advance.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    ex_imm_d   = ex_imm_q;
    ex_valid_d = ex_valid_q;
    cnt_d      = cnt_q;
    if (BRANCH_TAKEN) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end else if (!EX_STALL) begin
      if (load_use) begin
        ex_valid_d = 1'b0;
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
      end else begin
        ex_instr_d = id_instr_q;
        ex_pc_d    = id_pc_q;
        ex_imm_d   = imm_sel;
        ex_valid_d = id_valid_q;
        id_instr_d = IF_INSTRUCTION;
        id_pc_d    = IF_PC;
        id_valid_d = IF_VALID;
      end
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      ex_instr_q <= '0;
      ex_pc_q    <= '0;
      ex_imm_q   <= '0;
      ex_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    ID_INSTRUCTION = id_instr_q;
    ID_PC          = id_pc_q;
    ID_VALID       = id_valid_q;
    IMM_SELECT     = imm_sel;
    EX_INSTRUCTION = ex_instr_q;
    EX_PC          = ex_pc_q;
    EX_IMM_SELECT  = ex_imm_q;
    EX_VALID       = ex_valid_q;
    IF_STALL       = !RESET && !BRANCH_TAKEN && (EX_STALL || load_use);
    HAZARD_COUNT   = cnt_q;
  end
endmodule
